// File: rtl/decoder2_4_seq_if.sv
// Code handshake between an encoder-side source and the registered 2-to-4 decoder.
// The source drives the code and valid; the decoder returns ready.
interface decoder2_4_seq_if;
  logic valid_in;
  logic A1;
  logic A0;
  logic ready_out;

  modport master (
    output valid_in,
    output A1,
    output A0,
    input  ready_out
  );

  modport slave (
    input  valid_in,
    input  A1,
    input  A0,
    output ready_out
  );
endinterface

// File: rtl/decoder2_4_seq.sv
// Registered 2-to-4 decoder: each accepted code drives one one-hot line for HOLD_CYCLES,
// then GAP_CYCLES of zeros and one mandatory idle cycle. Scan mode self-generates codes 0..3.
module decoder2_4_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            scan,
  decoder2_4_seq_if.slave code_if,
  output logic            Y3,
  output logic            Y2,
  output logic            Y1,
  output logic            Y0,
  output logic            busy,
  output logic            done
);

  // state   | meaning
  // ST_IDLE | waiting for a handshake or scan accept; outputs low
  // ST_HOLD | one-hot line driven, counter runs down the hold time
  // ST_GAP  | outputs forced low, counter runs down the gap time
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       y_q, y_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             hs_accept;
  logic             scan_accept;
  logic [1:0]       code;
  logic             cnt_zero;

  // en and scan are re-qualified here so a level change since the last edge wins over ready_q.
  assign hs_accept   = (state_q == ST_IDLE) & en & ~scan & ready_q & code_if.valid_in;
  assign scan_accept = (state_q == ST_IDLE) & en & scan;
  assign code        = scan_accept ? idx_q : {code_if.A1, code_if.A0};
  assign cnt_zero    = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    y_d     = y_q;
    done_d  = 1'b0;

    if (!en) begin
      // abort: drop the line, forget the timer, keep the scan position
      state_d = ST_IDLE;
      cnt_d   = '0;
      y_d     = 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          y_d = 4'b0000;
          if (hs_accept || scan_accept) begin
            y_d     = 4'b0001 << code;
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
            if (scan_accept) begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
            y_d    = 4'b0000;
            done_d = 1'b1;
            if (HAS_GAP) begin
              state_d = ST_GAP;
              cnt_d   = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          y_d = 4'b0000;
          if (cnt_zero) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          y_d     = 4'b0000;
        end
      endcase
    end

    ready_d = (state_d == ST_IDLE) & en & ~scan;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      y_q     <= 4'b0000;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign code_if.ready_out = ready_q;
  assign {Y3, Y2, Y1, Y0}  = y_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_decoder2_4_seq.sv
// Directed bench for decoder2_4_seq: a negedge monitor closes each one-hot burst against a
// scoreboard of expected {line, length}; the main sequence checks latency, done and ready timing.
module tb_decoder2_4_seq;

  typedef struct {
    logic [3:0] y;
    int         len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, scan;
  logic Y3, Y2, Y1, Y0, busy, done;
  logic en0, scan0;
  logic z3, z2, z1, z0, busy0, done0;
  logic [3:0] yv, y0v;

  decoder2_4_seq_if bus ();
  decoder2_4_seq_if bus0 ();

  decoder2_4_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .scan(scan), .code_if(bus.slave),
    .Y3(Y3), .Y2(Y2), .Y1(Y1), .Y0(Y0), .busy(busy), .done(done)
  );

  decoder2_4_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) dut_g0 (
    .clk(clk), .rst(rst), .en(en0), .scan(scan0), .code_if(bus0.slave),
    .Y3(z3), .Y2(z2), .Y1(z1), .Y0(z0), .busy(busy0), .done(done0)
  );

  assign yv  = {Y3, Y2, Y1, Y0};
  assign y0v = {z3, z2, z1, z0};

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   run_len = 0;
  logic [3:0] run_val = 4'b0;
  logic mon_en = 1'b0;
  exp_t sb[$];

  function automatic logic [3:0] oh(input int c);
    logic [3:0] r;
    r = 4'b0001 << c;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic close_run();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_burst", 32'(run_val), 32'(0));
    end else begin
      e = sb.pop_front();
      check("burst_val", 32'(run_val), 32'(e.y));
      check("burst_len", 32'(run_len), 32'(e.len));
    end
    run_len = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("onehot", 32'($countones(yv) <= 1), 32'(1));
      check("y_outside_busy", 32'((busy == 1'b0) && (yv != 4'b0)), 32'(0));
      if (done === 1'b1) n_done++;
      if (run_len > 0 && yv != run_val) close_run();
      if (yv != 4'b0) begin
        if (run_len == 0) run_val = yv;
        run_len++;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "timeout");
  end

  initial begin
    int   codes[4];
    int   d0;
    logic [3:0] ey;
    codes = '{3, 2, 1, 0};

    rst = 1'b1; en = 1'b1; scan = 1'b0;
    bus.valid_in = 1'b1; bus.A1 = 1'b1; bus.A0 = 1'b1;
    en0 = 1'b0; scan0 = 1'b0;
    bus0.valid_in = 1'b0; bus0.A1 = 1'b0; bus0.A0 = 1'b0;

    // reset held with valid and en high
    tick();
    @(negedge clk);
    mon_en = 1'b1;
    check("rst_y", 32'(yv), 32'(0));
    check("rst_ready", 32'(bus.ready_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    tick();
    @(negedge clk);
    check("rst_ready2", 32'(bus.ready_out), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_ready", 32'(bus.ready_out), 32'(1));
    check("post_rst_y", 32'(yv), 32'(0));

    // decode 3,2,1,0 with valid held
    for (int i = 0; i < 4; i++) begin
      {bus.A1, bus.A0} = 2'(codes[i]);
      sb.push_back('{y: oh(codes[i]), len: 4});
      tick();
      @(negedge clk);
      check("dec_latency_y", 32'(yv), 32'(oh(codes[i])));
      check("dec_busy", 32'(busy), 32'(1));
      check("dec_ready_busy", 32'(bus.ready_out), 32'(0));
      repeat (3) tick();
      @(negedge clk);
      check("dec_last_hold", 32'(yv), 32'(oh(codes[i])));
      check("dec_no_early_done", 32'(done), 32'(0));
      tick();
      @(negedge clk);
      check("dec_done", 32'(done), 32'(1));
      check("dec_gap_y", 32'(yv), 32'(0));
      check("dec_gap_ready", 32'(bus.ready_out), 32'(0));
      tick();
      @(negedge clk);
      check("dec_idle_ready", 32'(bus.ready_out), 32'(1));
      check("dec_idle_done", 32'(done), 32'(0));
      check("dec_idle_busy", 32'(busy), 32'(0));
    end
    bus.valid_in = 1'b0;
    check("dec_done_count", 32'(n_done), 32'(4));

    // enable low blocks everything
    en = 1'b0; bus.valid_in = 1'b1; {bus.A1, bus.A0} = 2'b11;
    repeat (8) begin
      tick();
      @(negedge clk);
      check("enlow_ready", 32'(bus.ready_out), 32'(0));
      check("enlow_y", 32'(yv), 32'(0));
      check("enlow_busy", 32'(busy), 32'(0));
    end

    // abort on the second hold cycle
    en = 1'b1; {bus.A1, bus.A0} = 2'b10;
    tick();
    @(negedge clk);
    check("abort_ready", 32'(bus.ready_out), 32'(1));
    d0 = n_done;
    sb.push_back('{y: 4'b0100, len: 2});
    tick();
    @(negedge clk);
    check("abort_y_hold1", 32'(yv), 32'(4'b0100));
    bus.valid_in = 1'b0;
    tick();
    @(negedge clk);
    check("abort_y_hold2", 32'(yv), 32'(4'b0100));
    en = 1'b0;
    tick();
    @(negedge clk);
    check("abort_y", 32'(yv), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    tick();
    @(negedge clk);
    check("abort_done_count", 32'(n_done), 32'(d0));

    // re-enable and send 01
    en = 1'b1; bus.valid_in = 1'b1; {bus.A1, bus.A0} = 2'b01;
    tick();
    @(negedge clk);
    check("reen_ready", 32'(bus.ready_out), 32'(1));
    sb.push_back('{y: 4'b0010, len: 4});
    tick();
    @(negedge clk);
    check("reen_y", 32'(yv), 32'(4'b0010));
    bus.valid_in = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("reen_done", 32'(done), 32'(1));
    check("reen_y_off", 32'(yv), 32'(0));
    tick();
    @(negedge clk);
    check("reen_idle_ready", 32'(bus.ready_out), 32'(1));
    check("reen_done_count", 32'(n_done), 32'(d0 + 1));

    // scan with wrap; valid with code 11 must be ignored
    scan = 1'b1; bus.valid_in = 1'b1; {bus.A1, bus.A0} = 2'b11;
    for (int k = 0; k < 5; k++) sb.push_back('{y: oh(k % 4), len: 4});
    tick();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      ey = ((k % 6) < 4) ? oh((k / 6) % 4) : 4'b0000;
      check("scan_y", 32'(yv), 32'(ey));
      check("scan_ready", 32'(bus.ready_out), 32'(0));
    end
    scan = 1'b0; bus.valid_in = 1'b0;
    check("scan_done_count", 32'(n_done), 32'(d0 + 6));

    // reset in the middle of a hold
    tick();
    @(negedge clk);
    check("rmid_ready", 32'(bus.ready_out), 32'(1));
    bus.valid_in = 1'b1; {bus.A1, bus.A0} = 2'b00;
    sb.push_back('{y: 4'b0001, len: 2});
    d0 = n_done;
    tick();
    @(negedge clk);
    check("rmid_y", 32'(yv), 32'(4'b0001));
    bus.valid_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rmid_rst_y", 32'(yv), 32'(0));
    check("rmid_rst_done", 32'(done), 32'(0));
    check("rmid_rst_busy", 32'(busy), 32'(0));
    check("rmid_rst_ready", 32'(bus.ready_out), 32'(0));
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("rmid_after_done", 32'(done), 32'(0));
    check("rmid_done_count", 32'(n_done), 32'(d0));

    // zero-gap build: back-to-back codes 5 cycles apart
    en0 = 1'b1; bus0.valid_in = 1'b1; {bus0.A1, bus0.A0} = 2'b11;
    tick();
    @(negedge clk);
    check("g0_ready", 32'(bus0.ready_out), 32'(1));
    check("g0_y_idle", 32'(y0v), 32'(0));
    tick();
    @(negedge clk);
    check("g0_y3", 32'(y0v), 32'(4'b1000));
    {bus0.A1, bus0.A0} = 2'b10;
    repeat (4) tick();
    @(negedge clk);
    check("g0_done1", 32'(done0), 32'(1));
    check("g0_y_off", 32'(y0v), 32'(0));
    check("g0_ready_now", 32'(bus0.ready_out), 32'(1));
    tick();
    @(negedge clk);
    check("g0_y2_spacing", 32'(y0v), 32'(4'b0100));
    bus0.valid_in = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("g0_done2", 32'(done0), 32'(1));
    check("g0_y_off2", 32'(y0v), 32'(0));
    tick();
    @(negedge clk);
    check("g0_idle_busy", 32'(busy0), 32'(0));
    check("g0_idle_done", 32'(done0), 32'(0));

    repeat (2) tick();
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    check("open_run", 32'(run_len), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
